// File: rtl/etcpu_imem_loader_pkg.sv
// ============================================================
// Package : etcpu_loader_pkg
// Shared state encoding and constants for the imem boot loader.
// Revision: 1.0
// ============================================================
`default_nettype none

package etcpu_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } loader_state_t;

  localparam int LOADER_HOLD_W = 4;

endpackage

`default_nettype wire

// File: rtl/etcpu_imem_loader_if.sv
// ============================================================
// Interface : etcpu_imem_loader_if
// Program word stream in, instruction-memory write port out.
// Revision: 1.0
// ============================================================
`default_nettype none

interface etcpu_imem_loader_if;

  logic        s_vld;
  logic [31:0] s_dat;
  logic        s_rdy;
  logic        inst_mem_wr_wen;
  logic [31:0] inst_mem_wr_addr;
  logic [31:0] inst_mem_wr_dat;

  // master: host stream source / memory sink side
  modport master (
    output s_vld, s_dat,
    input  s_rdy, inst_mem_wr_wen, inst_mem_wr_addr, inst_mem_wr_dat
  );

  // slave: the loader itself
  modport slave (
    input  s_vld, s_dat,
    output s_rdy, inst_mem_wr_wen, inst_mem_wr_addr, inst_mem_wr_dat
  );

endinterface

`default_nettype wire

// File: rtl/etcpu_imem_loader.sv
// ============================================================
// Module : etcpu_imem_loader
// Writes a streamed program image into imem from address 0 and
// holds the CPU in reset until the image is complete.
// Optional feature macro: ETCPU_LOADER_CHECKSUM_EN
// Revision: 1.0
// ============================================================
`default_nettype none

module etcpu_imem_loader
  import etcpu_loader_pkg::*;
#(
  parameter int INST_MEM_DEPTH = 256,
  parameter int RST_HOLD_CYC   = 4
) (
  input  wire logic                              clk,
  input  wire logic                              rst_n,
  input  wire logic                              start,
  input  wire logic                              abort,
  input  wire logic [$clog2(INST_MEM_DEPTH):0]   load_len,
`ifdef ETCPU_LOADER_CHECKSUM_EN
  input  wire logic [31:0]                       exp_sum,
  output logic      [31:0]                       sum,
`endif
  etcpu_imem_loader_if.slave                     bus,
  output logic                                   rst_n_cpu,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);

  localparam int AW = $clog2(INST_MEM_DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(INST_MEM_DEPTH);
  localparam logic [LOADER_HOLD_W-1:0] C_HOLD_LAST = LOADER_HOLD_W'(RST_HOLD_CYC - 1);

  loader_state_t r_state, w_next;

  logic [AW-1:0]            r_cnt;
  logic [AW:0]              r_len;
  logic [LOADER_HOLD_W-1:0] r_hold;

  logic        r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_dat;

  logic w_s_rdy, w_beat, w_len_ok, w_last, w_hold_done, w_sum_ok, w_enter_load;
  logic w_busy_d, w_done_d, w_err_d, w_rst_cpu_d;

  assign w_len_ok     = (load_len != '0) && (load_len <= C_DEPTH);
  assign w_beat       = w_s_rdy && bus.s_vld;
  assign w_last       = ({1'b0, r_cnt} == (r_len - 1'b1));
  assign w_hold_done  = (r_hold == C_HOLD_LAST);
  assign w_enter_load = (w_next == LOAD) && (r_state != LOAD);

`ifdef ETCPU_LOADER_CHECKSUM_EN
  logic [31:0] r_exp_sum;
  assign w_sum_ok = (sum == r_exp_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      r_exp_sum <= '0;
    end else if (w_enter_load) begin
      sum       <= '0;
      r_exp_sum <= exp_sum;
    end else if (w_beat) begin
      sum       <= sum + bus.s_dat;
    end
  end
`else
  assign w_sum_ok = 1'b1;
`endif

  // State register plus the counters the FSM owns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      if (w_enter_load) begin
        r_cnt <= '0;
        r_len <= load_len;
      end else if (w_beat) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_hold <= (r_state == HOLD) ? r_hold + 1'b1 : '0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = w_len_ok ? LOAD : ERR;
      LOAD: begin
        if (abort)                w_next = IDLE;
        else if (w_beat && w_last) w_next = HOLD;
      end
      HOLD: if (w_hold_done) w_next = w_sum_ok ? RUN : ERR;
      RUN,
      ERR:  if (start) w_next = w_len_ok ? LOAD : ERR;
      default: w_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track it exactly
  always_comb begin
    w_s_rdy     = (r_state == LOAD) && !abort;
    w_busy_d    = (w_next == LOAD) || (w_next == HOLD);
    w_done_d    = (w_next == RUN);
    w_err_d     = (w_next == ERR);
    w_rst_cpu_d = (w_next == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_dat     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rst_n_cpu <= 1'b0;
    end else begin
      r_wen     <= w_beat;
      if (w_beat) begin
        r_addr <= 32'({r_cnt, 2'b00});
        r_dat  <= bus.s_dat;
      end
      busy      <= w_busy_d;
      done      <= w_done_d;
      err       <= w_err_d;
      rst_n_cpu <= w_rst_cpu_d;
    end
  end

  assign bus.s_rdy            = w_s_rdy;
  assign bus.inst_mem_wr_wen  = r_wen;
  assign bus.inst_mem_wr_addr = r_addr;
  assign bus.inst_mem_wr_dat  = r_dat;

endmodule

`default_nettype wire
